// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector between Decode and Execute: stalls PC and IF/ID and
// bubbles ID/EX when a load in E writes a register read by the instruction in D.
module hazard_detection_unit #(
    parameter int CNT_WIDTH        = 32,
    parameter int MAX_CONSEC_STALL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MemReadE,
    input  logic [4:0]           RD_E,
    input  logic [4:0]           Rs1_D,
    input  logic [4:0]           Rs2_D,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic                 FlushE,
    output logic                 HazardRs1,
    output logic                 HazardRs2,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic                 StallTimeout
);

    localparam int CONSEC_WIDTH = $clog2(MAX_CONSEC_STALL + 1);
    localparam logic [CONSEC_WIDTH-1:0] CONSEC_MAX = CONSEC_WIDTH'(MAX_CONSEC_STALL);

    logic                    load_writes_reg;
    logic                    stall;
    logic [CONSEC_WIDTH-1:0] consec;
    logic [CONSEC_WIDTH-1:0] consec_next;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_writes_reg = MemReadE && (RD_E != 5'd0);

    assign HazardRs1   = load_writes_reg && (RD_E == Rs1_D);
    assign HazardRs2   = load_writes_reg && (RD_E == Rs2_D);
    assign stall       = HazardRs1 || HazardRs2;
    assign PCWrite     = ~stall;
    assign IF_ID_Write = ~stall;
    assign FlushE      = stall;

    // NOTE: default assigned first so every path drives consec_next; no latch.
    always_comb begin
        consec_next = '0;
        if (stall) begin
            if (consec == CONSEC_MAX) consec_next = CONSEC_MAX;
            else                      consec_next = consec + CONSEC_WIDTH'(1);
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount   <= '0;
            consec       <= '0;
            StallTimeout <= 1'b0;
        end else begin
            if (stall && (StallCount != '1)) StallCount <= StallCount + CNT_WIDTH'(1);
            consec <= consec_next;
            if (consec_next == CONSEC_MAX) StallTimeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: combinational hazard vectors, stall
// statistics, watchdog, and counter saturation on a narrow-counter instance.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MemReadE;
    logic [4:0] RD_E, Rs1_D, Rs2_D;

    logic        pc_write, if_id_write, flush_e, hazard_rs1, hazard_rs2, timeout;
    logic [31:0] count;
    logic        pc_write4, if_id_write4, flush_e4, hazard_rs1_4, hazard_rs2_4, timeout4;
    logic [3:0]  count4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.CNT_WIDTH(32), .MAX_CONSEC_STALL(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadE(MemReadE), .RD_E(RD_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .PCWrite(pc_write), .IF_ID_Write(if_id_write),
        .FlushE(flush_e), .HazardRs1(hazard_rs1), .HazardRs2(hazard_rs2),
        .StallCount(count), .StallTimeout(timeout)
    );

    hazard_detection_unit #(.CNT_WIDTH(4), .MAX_CONSEC_STALL(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .MemReadE(MemReadE), .RD_E(RD_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .PCWrite(pc_write4), .IF_ID_Write(if_id_write4),
        .FlushE(flush_e4), .HazardRs1(hazard_rs1_4), .HazardRs2(hazard_rs2_4),
        .StallCount(count4), .StallTimeout(timeout4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_comb(input string tag, input logic pcw, input logic ifw,
                              input logic fl, input logic h1, input logic h2);
        check({tag, ".PCWrite"},     32'(pc_write),    32'(pcw));
        check({tag, ".IF_ID_Write"}, 32'(if_id_write), 32'(ifw));
        check({tag, ".FlushE"},      32'(flush_e),     32'(fl));
        check({tag, ".HazardRs1"},   32'(hazard_rs1),  32'(h1));
        check({tag, ".HazardRs2"},   32'(hazard_rs2),  32'(h2));
        check({tag, ".w4_FlushE"},   32'(flush_e4),    32'(fl));
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        MemReadE = mr;
        RD_E     = rd;
        Rs1_D    = r1;
        Rs2_D    = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag, input logic [31:0] exp_cnt, input logic exp_to,
                              input logic [3:0] exp_cnt4, input logic exp_to4);
        check({tag, ".StallCount"},     count,           exp_cnt);
        check({tag, ".StallTimeout"},   32'(timeout),    32'(exp_to));
        check({tag, ".StallCount_w4"},  32'(count4),     32'(exp_cnt4));
        check({tag, ".StallTimeout_w4"}, 32'(timeout4),  32'(exp_to4));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);

        // Combinational vectors applied while reset is held: outputs ignore rst_n.
        drive(1'b0, 5'd2, 5'd1, 5'd3);
        check_comb("no_load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd2, 5'd2, 5'd2);
        check_comb("no_load_match", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 5'd2, 5'd3);
        check_comb("rs1_hit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd1, 5'd3);
        check_comb("rs2_hit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 5'd3, 5'd3, 5'd3);
        check_comb("both_hit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 5'd4, 5'd1, 5'd2);
        check_comb("load_no_match", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd1);
        check_comb("x0_exempt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd31, 5'd30, 5'd31);
        check_comb("r31_rs2_hit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();

        // Two edges of reset with stalls present: counters must still be zero.
        drive(1'b0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        check_regs("after_reset", 32'd0, 1'b0, 4'd0, 1'b0);
        tick();
        check_regs("idle_edge", 32'd0, 1'b0, 4'd0, 1'b0);

        // Single-cycle load-use stall: counted, watchdog stays clear.
        drive(1'b1, 5'd2, 5'd2, 5'd0);
        tick();
        drive(1'b0, 5'd2, 5'd2, 5'd0);
        check_regs("single_stall", 32'd1, 1'b0, 4'd1, 1'b0);
        tick();
        check_regs("single_stall_idle", 32'd1, 1'b0, 4'd1, 1'b0);

        // Two back-to-back stalls set the sticky watchdog on the second edge.
        drive(1'b1, 5'd5, 5'd0, 5'd5);
        tick();
        check_regs("consec_1", 32'd2, 1'b0, 4'd2, 1'b0);
        tick();
        check_regs("consec_2", 32'd3, 1'b1, 4'd3, 1'b1);
        drive(1'b0, 5'd5, 5'd0, 5'd5);
        tick();
        check_regs("sticky_1", 32'd3, 1'b1, 4'd3, 1'b1);
        tick();
        check_regs("sticky_2", 32'd3, 1'b1, 4'd3, 1'b1);

        // Hold a stall for 20 edges: narrow counter saturates at 15, wide keeps counting.
        drive(1'b1, 5'd7, 5'd7, 5'd7);
        for (int i = 0; i < 12; i++) tick();
        check_regs("hold_12", 32'd15, 1'b1, 4'd15, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        check_regs("hold_20", 32'd23, 1'b1, 4'd15, 1'b1);

        // Reset pulse while stalling: registers clear, combinational path still stalls.
        rst_n = 1'b0;
        #1;
        check_comb("stall_in_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check_regs("reset_pulse", 32'd0, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_regs("post_reset_1", 32'd1, 1'b0, 4'd1, 1'b0);
        tick();
        check_regs("post_reset_2", 32'd2, 1'b1, 4'd2, 1'b1);

        // A broken stall run restarts the consecutive counter.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 5'd9, 5'd9, 5'd1);
        tick();
        drive(1'b0, 5'd9, 5'd9, 5'd1);
        tick();
        drive(1'b1, 5'd9, 5'd9, 5'd1);
        tick();
        check_regs("broken_run", 32'd2, 1'b0, 4'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Load-use hazard detector for the 5-stage pipelined RISC-V core, placed between the Decode (D) and Execute (E) stages. It compares the destination register of a load in E against the source registers of the instruction in D. On a match it stalls PC and IF/ID and flushes (bubbles) ID/EX. It also keeps clocked stall statistics and a stuck-stall watchdog for debug and verification.

Parameters:
CNT_WIDTH, 32, width of the saturating stall-event counter.
MAX_CONSEC_STALL, 2, consecutive stall cycles at or above which the watchdog flag sets.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
MemReadE  input  1  instruction in E is a load.
RD_E  input  5  destination register of the instruction in E.
Rs1_D  input  5  source register 1 of the instruction in D.
Rs2_D  input  5  source register 2 of the instruction in D.
PCWrite  output  1  PC update enable (0 = hold PC).
IF_ID_Write  output  1  IF/ID register write enable (0 = hold).
FlushE  output  1  clear ID/EX (insert bubble).
HazardRs1  output  1  hazard caused by Rs1_D.
HazardRs2  output  1  hazard caused by Rs2_D.
StallCount  output  CNT_WIDTH  number of cycles stalled since reset.
StallTimeout  output  1  sticky watchdog flag.

Behaviour:
- HazardRs1 = MemReadE & (RD_E != 0) & (RD_E == Rs1_D).
- HazardRs2 = MemReadE & (RD_E != 0) & (RD_E == Rs2_D).
- stall = HazardRs1 | HazardRs2.
- PCWrite = ~stall; IF_ID_Write = ~stall; FlushE = stall.
- All five signals above are purely combinational and take effect in the same cycle, with zero latency. They do not depend on clk or rst_n.
- x0 is never a hazard: RD_E == 0 gives stall = 0 even if Rs1_D or Rs2_D is 0.
- A match on both sources at once asserts both HazardRs1 and HazardRs2. stall is still a single 1.
- With MemReadE = 0, all hazard outputs are 0 regardless of register fields.
- StallCount:
  - Synchronous reset to 0 when rst_n = 0 at the rising edge.
  - Otherwise increments by 1 on each rising edge where stall = 1.
  - Saturates at all-ones and never wraps.
- Consecutive-stall counter (internal, width sufficient for MAX_CONSEC_STALL):
  - Reset to 0.
  - On a rising edge with stall = 1, increments and saturates at MAX_CONSEC_STALL.
  - On a rising edge with stall = 0, clears to 0.
- StallTimeout:
  - Reset to 0.
  - Sets on the rising edge where the consecutive counter's next value reaches MAX_CONSEC_STALL.
  - Sticky until reset.
  - With the default of 2, a normal single-cycle load-use stall never sets it. Two back-to-back stalled edges set it.
- Reset while stall = 1: the registers take their reset values at that edge. The combinational outputs still reflect the inputs.
- No X propagation from the registers: all state has a defined reset value.

Test Plan:
1. MemReadE=0, RD_E=2, Rs1_D=1, Rs2_D=3 -> PCWrite=1, IF_ID_Write=1, FlushE=0, HazardRs1=0, HazardRs2=0.
2. MemReadE=1, RD_E=2, Rs1_D=2, Rs2_D=3 -> PCWrite=0, IF_ID_Write=0, FlushE=1, HazardRs1=1, HazardRs2=0.
3. MemReadE=1, RD_E=3, Rs1_D=1, Rs2_D=3 -> PCWrite=0, IF_ID_Write=0, FlushE=1, HazardRs2=1; also Rs1_D=3, Rs2_D=3 -> both Hazard flags 1.
4. MemReadE=1, RD_E=4, Rs1_D=1, Rs2_D=2 -> PCWrite=1, IF_ID_Write=1, FlushE=0; and MemReadE=1, RD_E=0, Rs1_D=0, Rs2_D=1 -> PCWrite=1, FlushE=0 (x0 exempt).
5. Hold rst_n=0 for 2 edges, then release -> StallCount=0, StallTimeout=0. Apply hazard for 1 edge, then none -> StallCount=1, StallTimeout=0. Then hazard for 2 consecutive edges -> StallCount=3, StallTimeout=1, and it stays 1 after the hazard clears.
6. With CNT_WIDTH=4, hold hazard for 20 edges -> StallCount saturates at 15. Then pulse rst_n=0 for one edge -> StallCount=0, StallTimeout=0.
